serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add/subtract sequencer that time-shares a single 1-bit full-adder cell to compute WIDTH-bit sums and differences, one bit per clock, LSB first. It sits beside the ALU as a low-area arithmetic unit and is driven by a start/done handshake. It owns the operand shift registers, the carry flip-flop, the bit counter and the control FSM. The full-adder cell is instantiated exactly once and is purely combinational.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  reset is synchronous and active-high
- start  input  1  request; sampled only in IDLE or DONE
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result valid
- sum  output  WIDTH  result; held stable from done until next accepted start
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- Full-adder cell ports: sum, cout, a, b, cin. Its inputs are shift-A LSB, shift-B LSB and the carry FF.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: load shA←a and shB←(sub ? ~b : b). Load carry FF←sub. Clear bit counter to 0. Go to RUN.
- IDLE, start=0: stay.
- RUN, every edge:
  - shift shA and shB right by 1.
  - shift the cell sum into the MSB of the result shift register (right shift).
  - carry FF ← cell cout.
  - counter +1.
  - On the edge where counter = WIDTH−1:
    - capture cell cout into cout.
    - capture (carry FF XOR cell cout) into overflow, because the carry FF holds the carry into the MSB at that point.
    - go to DONE.
- DONE: done=1 for exactly this cycle.
  - If start=1 in DONE, accept a new operation as from IDLE (back-to-back) and go to RUN.
  - Otherwise go to IDLE.
- start is ignored while in RUN. Operands are not re-sampled and there is no abort.
- Counter width: $clog2(WIDTH). No wrap beyond WIDTH−1 in RUN.
- sum, cout and overflow change only on the final RUN edge.
  - The result shift register is separate from the sum output register, so sum does not ripple during RUN.
  - sum is loaded from {cell sum, shifted bits} on that final edge.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, counter=0, carry FF=0.
- Reset has priority over everything, including mid-RUN. The operation is discarded and no done is issued.
- Start accepted at edge E0. busy=1 for cycles after E0 through E(WIDTH). done=1 in the cycle after E(WIDTH). Latency is WIDTH cycles from accept to done.
- Throughput: one operation per WIDTH+1 cycles. With back-to-back start in DONE it is one per WIDTH+1, and done and busy are never high together.
- The combinational path runs carry FF → cell → carry FF. The cell's modelled worst-case delay is 150 ns (three 50 ns gate levels). Bench clock period must be ≥ 400 ns.

## Test plan
All scenarios use WIDTH=8.
- Add: a=8'h5A, b=8'h33, sub=0 → done 8 cycles after accept; sum=8'h8D, cout=0, overflow=1.
- Sub: a=8'h10, b=8'h20, sub=1 → sum=8'hF0, cout=0, overflow=0. Also a=8'h80, b=8'h01, sub=1 → sum=8'h7F, cout=1, overflow=1.
- Wrap: a=8'hFF, b=8'h01, sub=0 → sum=8'h00, cout=1, overflow=0.
- Ignore during busy: start a=8'h01+b=8'h01, then pulse start with a=8'hF0, b=8'hF0 mid-RUN → sum=8'h02, one done pulse only, busy high 8 cycles.
- Reset mid-op: assert reset at bit 4 of a run → next cycle busy=0, done=0, sum=0, cout=0, overflow=0. No done follows. A new start then completes normally.
- Back-to-back: hold start=1 continuously with alternating operands → done every 9 cycles, each sum correct, busy low only during done cycles.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, one bit per clock, LSB first.
// Operands load on an accepted start; the result is presented on a one-cycle done pulse.
`timescale 1ns/1ps

module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_cat;
    logic             last;
    logic             accept;

    serial_add_fa u_fa (
        .a   (sha_q[0]),
        .b   (shb_q[0]),
        .cin (carry_q),
        .sum (fa_s),
        .cout(fa_co)
    );

    // Result bits so far with the current cell sum on top; the shift register
    // keeps the upper WIDTH-1 bits, the full value becomes sum on the last edge.
    assign res_cat = {fa_s, res_q};
    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign accept  = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    sha_d   = a;
                    shb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                res_d   = res_cat[WIDTH-1:1];
                carry_d = fa_co;
                if (last) begin
                    sum_d   = res_cat;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl (WIDTH=8) against an
// arithmetic reference model.
`timescale 1ns/1ps

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_hold = '0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .overflow(overflow)
    );

    always #200 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic s);
        int ux, uy, sx, sy, ur, sr;
        logic c, v;
        logic [W-1:0] r;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 2**(W-1)) ? ux - 2**W : ux;
        sy = (uy >= 2**(W-1)) ? uy - 2**W : uy;
        if (s) begin
            ur = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end else begin
            ur = ux + uy;
            sr = sx + sy;
            c  = (ur >= 2**W);
        end
        v = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
        r = ur[W-1:0];
        return {v, c, r};
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input int inj);
        logic [W+1:0] e;
        int cyc;
        int nb;
        e = model(x, y, s);
        nb = 0;
        @(negedge clk);
        a = x;
        b = y;
        sub = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc <= 3 * W) begin
            if (busy) nb++;
            chk("sum_hold", sum, exp_hold);
            if (cyc == inj) begin
                start = 1'b1;
                a = 8'hF0;
                b = 8'hF0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", cyc - 1, W);
        chk("busy_cycles", nb, W);
        chk("busy_with_done", busy, 0);
        chk("sum", sum, e[W-1:0]);
        chk("cout", cout, e[W]);
        chk("overflow", overflow, e[W+1]);
        exp_hold = e[W-1:0];
        @(negedge clk);
        chk("done_one_pulse", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic reset_mid_op();
        int nd;
        @(negedge clk);
        a = 8'h37;
        b = 8'h11;
        sub = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        exp_hold = '0;
        nd = 0;
        repeat (3 * W) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("rst_no_done", nd, 0);
    endtask

    task automatic back_to_back(input int n);
        logic [W-1:0] xa[8];
        logic [W-1:0] xb[8];
        logic         xs[8];
        logic [W+1:0] e;
        int cyc;
        for (int i = 0; i < n; i++) begin
            xa[i] = W'($urandom);
            xb[i] = W'($urandom);
            xs[i] = i[0];
        end
        @(negedge clk);
        a = xa[0];
        b = xb[0];
        sub = xs[0];
        start = 1'b1;
        for (int k = 0; k < n; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (!done) chk("b2b_busy", busy, 1);
            end while (!done && cyc < 4 * W);
            e = model(xa[k], xb[k], xs[k]);
            chk("b2b_gap", cyc, W + 1);
            chk("b2b_busy_done", busy, 0);
            chk("b2b_sum", sum, e[W-1:0]);
            chk("b2b_cout", cout, e[W]);
            chk("b2b_ovf", overflow, e[W+1]);
            exp_hold = e[W-1:0];
            if (k < n - 1) begin
                a = xa[k+1];
                b = xb[k+1];
                sub = xs[k+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_end_done", done, 0);
        chk("b2b_end_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", overflow, 0);
        reset = 1'b0;

        run_op(8'h5A, 8'h33, 1'b0, 0);
        run_op(8'h10, 8'h20, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b1, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h01, 8'h01, 1'b0, 3);
        run_op(8'h7F, 8'h7F, 1'b0, 0);
        run_op(8'h00, 8'h00, 1'b1, 0);

        reset_mid_op();
        run_op(8'h3C, 8'h0F, 1'b0, 0);

        back_to_back(6);

        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                   (i % 4 == 0) ? int'($urandom_range(1, W - 1)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
